ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Instruction sequencer and control unit that sits directly upstream of the accumulator/ALU/flags datapath. It fetches 16-bit instruction words from program memory over a req/ack handshake, decodes them and drives the datapath controls (data source, immediate, ALU op, accumulator and carry clock-enables). It also drives register-file and data-memory strobes, and evaluates conditional jumps against the registered flags. It is a multi-cycle design: one instruction is in flight at a time.

## Interface
- WIDTH, 8, datapath width. The immediate is the zero-extended ir[7:0].
- PC_WIDTH, 8, program counter width. Jump targets are the zero-extended ir[7:0], truncated to PC_WIDTH.
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset: one clock; reset is synchronous and active-low
- prog_addr  out  PC_WIDTH  fetch address, equal to pc
- prog_req  out  1  fetch request
- prog_ack  in  1  fetch complete; prog_data valid in the same cycle
- prog_data  in  16  instruction word
- data_src  out  2  ALU input select: 00 mem, 01 imm, 11 reg
- immediate  out  WIDTH  immediate value
- op  out  3  ALU operation
- ce_a  out  1  accumulator/flags clock-enable pulse
- ce_cy  out  1  carry clock-enable pulse
- reg_sel  out  3  register index, equal to ir[2:0]
- reg_we  out  1  register-file write of the accumulator
- mem_addr  out  8  data-memory address, equal to ir[7:0]
- mem_re / mem_we  out  1 each  data-memory read/write request
- mem_ack  in  1  data-memory complete; read data valid in the same cycle
- flag_cy, flag_z, flag_s, flag_o  in  1 each  flags from the datapath
- pc  out  PC_WIDTH  program counter
- halted  out  1  core stopped
- illegal  out  1  stopped on an undefined opcode

## Operation
- Instruction classes, selected by ir[15:13]:
  - 000 ALU: op=ir[12:10], src=ir[9:8]. src 10 is illegal.
  - 001 STR: register[ir[2:0]] ← acc.
  - 010 STM: mem[ir[7:0]] ← acc.
  - 011 JMP: pc ← ir[7:0].
  - 100 JCC: condition ir[12:11] selects Z, CY, S or O (00/01/10/11); ir[10]=1 inverts the condition; taken means pc ← ir[7:0].
  - 111 HLT.
  - 101 and 110 are illegal.
- op, data_src, immediate, reg_sel and mem_addr are decoded combinationally from ir in every state. All strobes (prog_req, ce_a, ce_cy, reg_we, mem_re, mem_we) are asserted only as listed below and are 0 otherwise.
- States: FETCH, EXEC, MEM, HALT.
- FETCH
  - prog_req=1.
  - On prog_ack: ir ← prog_data, pc ← pc+1 (wrapping modulo 2^PC_WIDTH), go to EXEC.
- EXEC
  - ALU with imm or reg source: ce_a=ce_cy=1 for one cycle, then FETCH.
  - ALU with mem source, or STM: go to MEM.
  - STR: reg_we=1 for one cycle, then FETCH.
  - JMP: pc ← target, then FETCH.
  - JCC: condition evaluated on the flag inputs in this cycle. If taken, pc ← target; otherwise pc is unchanged (already pc+1). Then FETCH.
  - HLT: go to HALT.
  - Illegal: go to HALT and set illegal ← 1.
- MEM
  - mem_re (ALU) or mem_we (STM) is held high until mem_ack.
  - For ALU, ce_a=ce_cy=1 in the mem_ack cycle only.
  - On mem_ack, go to FETCH.
- HALT
  - halted=1; all strobes 0.
  - Held until reset.
- Reset (rst=0 at an edge): state ← FETCH, pc ← 0, ir ← 0, halted ← 0, illegal ← 0.
  - While rst=0, all strobes are 0 combinationally. A transaction in flight (prog_req, mem_re, mem_we) is abandoned; an ack arriving during reset is ignored.

## Timing
- Fetch takes 1 cycle if prog_ack arrives in the same cycle as prog_req; otherwise prog_req and prog_addr are held stable until ack.
- Cycles per instruction, with zero-wait memory:
  - ALU imm/reg, STR, JMP, JCC: 2 (FETCH, EXEC).
  - ALU mem, STM: 3 (FETCH, EXEC, MEM).
- The first prog_req is in the first cycle with rst=1.
- ce_a and ce_cy are single-cycle pulses. The new accumulator and flags are visible in the following cycle, which is always a FETCH. JCC therefore always sees the flags of the preceding instruction.
- pc wraps 2^PC_WIDTH−1 → 0 without any side effect.
- A jump to its own address loops forever without halting.

## Test plan
- Program ALU-imm (op 000, imm 0x05), STR r3, HLT with zero-wait memory → ce_a pulses at cycle 2; reg_we pulses with reg_sel=3 at cycle 4; halted=1 after 6 cycles; pc=3.
- ALU mem-source at address 0x40 with mem_ack delayed 3 cycles → mem_re held 4 cycles with mem_addr=0x40 and data_src=00; ce_a asserted only in the ack cycle.
- JCC on Z (ir[12:10]=000) with flag_z=1 → pc=target. With flag_z=0 → pc=old pc+1. Inverted variant (ir[10]=1) → the opposite outcome in each case.
- Opcode class 101 at address 0x07 → halted=1, illegal=1, pc=0x08; no strobes asserted afterwards.
- prog_ack withheld 5 cycles, then rst driven 0 for 1 cycle while MEM is waiting → all strobes drop in that cycle; pc=0 and FETCH of address 0 follow.
- pc=0xFF executing a non-jump → next fetch from address 0x00.

Source files
------------

// File: rtl/ctrl_seq.sv
// Multi-cycle instruction sequencer: fetches 16-bit words over req/ack, decodes them
// and drives the accumulator/ALU datapath, register-file and data-memory strobes.
module ctrl_seq #(
    parameter int WIDTH    = 8,
    parameter int PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] prog_addr,
    output logic                prog_req,
    input  logic                prog_ack,
    input  logic [15:0]         prog_data,
    output logic [1:0]          data_src,
    output logic [WIDTH-1:0]    immediate,
    output logic [2:0]          op,
    output logic                ce_a,
    output logic                ce_cy,
    output logic [2:0]          reg_sel,
    output logic                reg_we,
    output logic [7:0]          mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    input  logic                mem_ack,
    input  logic                flag_cy,
    input  logic                flag_z,
    input  logic                flag_s,
    input  logic                flag_o,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic                illegal,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [2:0] C_ALU = 3'b000;
    localparam logic [2:0] C_STR = 3'b001;
    localparam logic [2:0] C_STM = 3'b010;
    localparam logic [2:0] C_JMP = 3'b011;
    localparam logic [2:0] C_JCC = 3'b100;
    localparam logic [2:0] C_HLT = 3'b111;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic                illegal_q, illegal_d;

    logic                req_c, ce_c, reg_we_c, mem_re_c, mem_we_c;
    logic                cond_c;
    logic [2:0]          cls;
    logic [PC_WIDTH-1:0] target;

    assign cls       = ir_q[15:13];
    assign target    = PC_WIDTH'(ir_q[7:0]);
    assign op        = ir_q[12:10];
    assign data_src  = ir_q[9:8];
    assign immediate = WIDTH'(ir_q[7:0]);
    assign reg_sel   = ir_q[2:0];
    assign mem_addr  = ir_q[7:0];

    assign prog_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;
    assign dbg_state = state_q;

    // Reset kills every strobe combinationally so in-flight transactions are dropped at once.
    assign prog_req = rst & req_c;
    assign ce_a     = rst & ce_c;
    assign ce_cy    = rst & ce_c;
    assign reg_we   = rst & reg_we_c;
    assign mem_re   = rst & mem_re_c;
    assign mem_we   = rst & mem_we_c;

    always_comb begin
        case (ir_q[12:11])
            2'b00:   cond_c = flag_z;
            2'b01:   cond_c = flag_cy;
            2'b10:   cond_c = flag_s;
            default: cond_c = flag_o;
        endcase
        cond_c = cond_c ^ ir_q[10];
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        req_c     = 1'b0;
        ce_c      = 1'b0;
        reg_we_c  = 1'b0;
        mem_re_c  = 1'b0;
        mem_we_c  = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (prog_ack) begin
                    ir_d    = prog_data;
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (cls)
                    C_ALU: begin
                        if (ir_q[9:8] == 2'b10) begin
                            state_d   = S_HALT;
                            illegal_d = 1'b1;
                        end else if (ir_q[9:8] == 2'b00) begin
                            state_d = S_MEM;
                        end else begin
                            ce_c = 1'b1;
                        end
                    end
                    C_STR: reg_we_c = 1'b1;
                    C_STM: state_d = S_MEM;
                    C_JMP: pc_d = target;
                    C_JCC: if (cond_c) pc_d = target;
                    C_HLT: state_d = S_HALT;
                    default: begin
                        state_d   = S_HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                // Only ALU-from-memory and STM ever reach this state.
                if (cls == C_STM) mem_we_c = 1'b1;
                else              mem_re_c = 1'b1;
                if (mem_ack) begin
                    ce_c    = (cls == C_ALU);
                    state_d = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: program/data memory responders with programmable
// wait states, one task per scenario, and a single summary line.
module tb_ctrl_seq;

    logic        clk;
    logic        rst;
    logic [7:0]  prog_addr;
    logic        prog_req;
    logic        prog_ack;
    logic [15:0] prog_data;
    logic [1:0]  data_src;
    logic [7:0]  immediate;
    logic [2:0]  op;
    logic        ce_a, ce_cy;
    logic [2:0]  reg_sel;
    logic        reg_we;
    logic [7:0]  mem_addr;
    logic        mem_re, mem_we, mem_ack;
    logic        flag_cy, flag_z, flag_s, flag_o;
    logic [7:0]  pc;
    logic        halted, illegal;
    logic [1:0]  dbg_state;

    logic [15:0] pmem [256];
    int          prog_wait, mem_wait, pcnt, mcnt;
    int          errors, checks;

    ctrl_seq #(.WIDTH(8), .PC_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .prog_addr(prog_addr), .prog_req(prog_req), .prog_ack(prog_ack), .prog_data(prog_data),
        .data_src(data_src), .immediate(immediate), .op(op), .ce_a(ce_a), .ce_cy(ce_cy),
        .reg_sel(reg_sel), .reg_we(reg_we), .mem_addr(mem_addr),
        .mem_re(mem_re), .mem_we(mem_we), .mem_ack(mem_ack),
        .flag_cy(flag_cy), .flag_z(flag_z), .flag_s(flag_s), .flag_o(flag_o),
        .pc(pc), .halted(halted), .illegal(illegal), .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responders: decide ack 2ns after each rising edge from the current strobes.
    initial begin
        prog_ack = 1'b0; mem_ack = 1'b0; prog_data = 16'h0000; pcnt = 0; mcnt = 0;
        forever begin
            @(posedge clk); #2;
            if (prog_req) begin
                if (pcnt >= prog_wait) begin
                    prog_ack = 1'b1; prog_data = pmem[prog_addr]; pcnt = 0;
                end else begin
                    prog_ack = 1'b0; pcnt++;
                end
            end else begin
                prog_ack = 1'b0; pcnt = 0;
            end
            if (mem_re || mem_we) begin
                if (mcnt >= mem_wait) begin
                    mem_ack = 1'b1; mcnt = 0;
                end else begin
                    mem_ack = 1'b0; mcnt++;
                end
            end else begin
                mem_ack = 1'b0; mcnt = 0;
            end
        end
    end

    // Driver tasks
    task automatic clear_prog();
        for (int i = 0; i < 256; i++) pmem[i] = 16'hE000;
        prog_wait = 0; mem_wait = 0;
        flag_cy = 0; flag_z = 0; flag_s = 0; flag_o = 0;
    endtask

    // Leaves the bench sampling cycle 1 (first cycle with rst=1).
    task automatic apply_reset();
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1; #3;
    endtask

    task automatic next_cycle();
        @(posedge clk); #4;
    endtask

    // Scenario tasks
    task automatic test_reset();
        clear_prog();
        pmem[0] = 16'h6000;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #4;
        checks++; if ({prog_req, ce_a, ce_cy, reg_we, mem_re, mem_we} !== 6'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 000000", {prog_req, ce_a, ce_cy, reg_we, mem_re, mem_we}); end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", pc); end
        checks++; if ({halted, illegal} !== 2'b00) begin errors++; $display("FAIL reset_halt: got %b expected 00", {halted, illegal}); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        @(posedge clk); #1; rst = 1'b1; #3;
        checks++; if (prog_req !== 1'b1 || prog_addr !== 8'h00) begin errors++; $display("FAIL first_fetch: got req=%b addr=%h expected req=1 addr=00", prog_req, prog_addr); end
        // A jump to itself spins without ever halting.
        for (int c = 2; c <= 11; c++) next_cycle();
        checks++; if (halted !== 1'b0 || prog_addr !== 8'h00 || prog_req !== 1'b1) begin errors++; $display("FAIL self_loop: got halted=%b addr=%h req=%b expected 0/00/1", halted, prog_addr, prog_req); end
    endtask

    task automatic test_basic();
        clear_prog();
        pmem[0] = 16'h0105;  // ALU op0, imm 0x05
        pmem[1] = 16'h2003;  // STR r3
        pmem[2] = 16'hE000;  // HLT
        apply_reset();
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) next_cycle();
            checks++; if (ce_a !== (c == 2) || ce_cy !== (c == 2)) begin errors++; $display("FAIL basic_ce cycle %0d: got %b%b expected %b", c, ce_a, ce_cy, (c == 2)); end
            checks++; if (reg_we !== (c == 4)) begin errors++; $display("FAIL basic_reg_we cycle %0d: got %b expected %b", c, reg_we, (c == 4)); end
            checks++; if (halted !== (c == 7)) begin errors++; $display("FAIL basic_halted cycle %0d: got %b expected %b", c, halted, (c == 7)); end
            checks++; if (prog_req !== (c % 2 == 1 && c < 7)) begin errors++; $display("FAIL basic_req cycle %0d: got %b expected %b", c, prog_req, (c % 2 == 1 && c < 7)); end
            if (c == 2) begin
                checks++; if (immediate !== 8'h05 || data_src !== 2'b01 || op !== 3'd0) begin errors++; $display("FAIL basic_decode: got imm=%h src=%b op=%0d expected 05/01/0", immediate, data_src, op); end
            end
            if (c == 4) begin
                checks++; if (reg_sel !== 3'd3) begin errors++; $display("FAIL basic_reg_sel: got %0d expected 3", reg_sel); end
            end
        end
        checks++; if (pc !== 8'h03 || illegal !== 1'b0) begin errors++; $display("FAIL basic_end: got pc=%h illegal=%b expected 03/0", pc, illegal); end
    endtask

    task automatic test_mem_alu();
        clear_prog();
        pmem[0] = 16'h0C40;  // ALU op3, mem source, addr 0x40
        mem_wait = 3;
        apply_reset();
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) next_cycle();
            checks++; if (mem_re !== (c >= 3 && c <= 6)) begin errors++; $display("FAIL mem_re cycle %0d: got %b expected %b", c, mem_re, (c >= 3 && c <= 6)); end
            checks++; if (ce_a !== (c == 6)) begin errors++; $display("FAIL mem_ce_a cycle %0d: got %b expected %b", c, ce_a, (c == 6)); end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL mem_we cycle %0d: got %b expected 0", c, mem_we); end
            if (c >= 3 && c <= 6) begin
                checks++; if (mem_addr !== 8'h40 || data_src !== 2'b00 || op !== 3'd3) begin errors++; $display("FAIL mem_decode cycle %0d: got addr=%h src=%b op=%0d expected 40/00/3", c, mem_addr, data_src, op); end
            end
        end
        checks++; if (prog_req !== 1'b1 || prog_addr !== 8'h01) begin errors++; $display("FAIL mem_next_fetch: got req=%b addr=%h expected 1/01", prog_req, prog_addr); end
    endtask

    task automatic test_jcc();
        logic [15:0] words [9];
        logic [3:0]  flags [9];   // {cy, z, s, o}
        logic [7:0]  exp_pc [9];
        words = '{16'h8020, 16'h8020, 16'h8420, 16'h8420, 16'h8820, 16'h8820, 16'h9020, 16'h9820, 16'h9820};
        flags = '{4'b0100,  4'b0000,  4'b0100,  4'b0000,  4'b1000,  4'b0100,  4'b0010,  4'b0001,  4'b0010};
        exp_pc = '{8'h20,   8'h01,    8'h01,    8'h20,    8'h20,    8'h01,    8'h20,    8'h20,    8'h01};
        for (int k = 0; k < 9; k++) begin
            clear_prog();
            pmem[0] = words[k];
            {flag_cy, flag_z, flag_s, flag_o} = flags[k];
            apply_reset();
            next_cycle();
            next_cycle();
            checks++; if (pc !== exp_pc[k] || prog_addr !== exp_pc[k]) begin errors++; $display("FAIL jcc_%0d: got pc=%h addr=%h expected %h", k, pc, prog_addr, exp_pc[k]); end
        end
    endtask

    task automatic test_illegal();
        logic any;
        clear_prog();
        pmem[0] = 16'h6007;  // JMP 0x07
        pmem[7] = 16'hA000;  // class 101
        apply_reset();
        next_cycle(); next_cycle();
        checks++; if (prog_addr !== 8'h07 || prog_req !== 1'b1) begin errors++; $display("FAIL jmp_target: got addr=%h req=%b expected 07/1", prog_addr, prog_req); end
        next_cycle(); next_cycle();
        checks++; if (halted !== 1'b1 || illegal !== 1'b1 || pc !== 8'h08) begin errors++; $display("FAIL illegal_stop: got halted=%b illegal=%b pc=%h expected 1/1/08", halted, illegal, pc); end
        any = 1'b0;
        for (int c = 0; c < 5; c++) begin
            any = any | prog_req | ce_a | ce_cy | reg_we | mem_re | mem_we;
            next_cycle();
        end
        checks++; if (any !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL illegal_quiet: got strobes=%b halted=%b expected 0/1", any, halted); end
        // Reserved ALU source 10 is also illegal.
        clear_prog();
        pmem[0] = 16'h0200;
        apply_reset();
        next_cycle(); next_cycle();
        checks++; if (halted !== 1'b1 || illegal !== 1'b1 || pc !== 8'h01 || ce_a !== 1'b0) begin errors++; $display("FAIL illegal_src: got halted=%b illegal=%b pc=%h ce_a=%b expected 1/1/01/0", halted, illegal, pc, ce_a); end
    endtask

    task automatic test_reset_in_mem();
        clear_prog();
        pmem[0] = 16'h4055;  // STM 0x55
        prog_wait = 5;
        mem_wait = 1000;
        apply_reset();
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) next_cycle();
            checks++; if (prog_req !== 1'b1 || prog_addr !== 8'h00 || prog_ack !== (c == 6)) begin errors++; $display("FAIL fetch_wait cycle %0d: got req=%b addr=%h ack=%b expected 1/00/%b", c, prog_req, prog_addr, prog_ack, (c == 6)); end
        end
        next_cycle(); next_cycle(); next_cycle();
        checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 8'h55 || dbg_state !== 2'd2) begin errors++; $display("FAIL stm_wait: got we=%b re=%b addr=%h state=%0d expected 1/0/55/2", mem_we, mem_re, mem_addr, dbg_state); end
        prog_wait = 0;
        @(posedge clk); #1; rst = 1'b0; #3;
        checks++; if ({prog_req, ce_a, ce_cy, reg_we, mem_re, mem_we} !== 6'b0) begin errors++; $display("FAIL reset_mem_strobes: got %b expected 000000", {prog_req, ce_a, ce_cy, reg_we, mem_re, mem_we}); end
        @(posedge clk); #1; rst = 1'b1; #3;
        checks++; if (pc !== 8'h00 || prog_req !== 1'b1 || prog_addr !== 8'h00 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_refetch: got pc=%h req=%b addr=%h we=%b expected 00/1/00/0", pc, prog_req, prog_addr, mem_we); end
    endtask

    task automatic test_pc_wrap();
        clear_prog();
        pmem[0]   = 16'h60FF;  // JMP 0xFF
        pmem[255] = 16'h0101;  // ALU imm, not a jump
        apply_reset();
        next_cycle(); next_cycle();
        checks++; if (prog_addr !== 8'hFF) begin errors++; $display("FAIL wrap_fetch_ff: got %h expected ff", prog_addr); end
        next_cycle();
        checks++; if (pc !== 8'h00 || ce_a !== 1'b1) begin errors++; $display("FAIL wrap_pc: got pc=%h ce_a=%b expected 00/1", pc, ce_a); end
        next_cycle();
        checks++; if (prog_addr !== 8'h00 || prog_req !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL wrap_next_fetch: got addr=%h req=%b halted=%b expected 00/1/0", prog_addr, prog_req, halted); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        clear_prog();
        test_reset();
        test_basic();
        test_mem_alu();
        test_jcc();
        test_illegal();
        test_reset_in_mem();
        test_pc_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
